// File: rtl/seg_scan_if.sv
// Load channel for seg_scan_ctrl: one 8-nibble display word per valid/ready handshake.
// The producer drives digits_in/load_valid; the scanner returns load_ready.
interface seg_scan_if;
    logic [31:0] digits_in;
    logic        load_valid;
    logic        load_ready;

    modport master (output digits_in, output load_valid, input load_ready);
    modport slave  (input digits_in, input load_valid, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed seven-segment display with per-slot
// blanking, frame-aligned word commit and optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int          DWELL_CYCLES = 20000,
    parameter int          BLANK_CYCLES = 400,
    parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   load,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [7:0]  an,
    output logic        frame_start
);

    localparam int              CW       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [31:0]     SHOW_LEN = 32'(DWELL_CYCLES - BLANK_CYCLES);

    logic [CW-1:0] cnt_p0;
    logic [2:0]    sel_p0;
    logic          vld_p0;
    logic [31:0]   active;
    logic [31:0]   pending;
    logic          pending_full;

    logic          show_p0;
    logic          last_p0;
    logic          boundary_p0;
    logic          accept;

    logic [7:0]    an_p1;
    logic [3:0]    digit_p1;
    logic          fs_p1;

    // Nibble idx of word, replaced by BLANK_CODE when it and every more
    // significant nibble are zero; the rightmost digit always shows.
    function automatic logic [3:0] lz_nibble(input logic [31:0] word,
                                             input logic [2:0]  idx,
                                             input logic        lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(idx) && word[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (lz && idx != 3'd0 && upper_zero) return BLANK_CODE;
        return word[{idx, 2'b00} +: 4];
    endfunction

    always_comb begin
        show_p0     = (32'(cnt_p0) < SHOW_LEN);
        last_p0     = (cnt_p0 == CNT_LAST);
        boundary_p0 = vld_p0 && last_p0 && (sel_p0 == 3'd7);
        accept      = load.load_valid && load.load_ready;
    end

    // vld_p0 holds scanning off for one cycle after reset so the first frame
    // starts on the second cycle after release.
    assign load.load_ready = vld_p0 & ~pending_full;

    // p0: scan position, word buffers -> p1: registered anode/digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_p0       <= '0;
            sel_p0       <= 3'd0;
            vld_p0       <= 1'b0;
            active       <= 32'h0;
            pending_full <= 1'b0;
            an_p1        <= 8'hFF;
            digit_p1     <= 4'h0;
            fs_p1        <= 1'b0;
        end else begin
            vld_p0 <= 1'b1;
            if (vld_p0) begin
                if (last_p0) begin
                    cnt_p0 <= '0;
                    sel_p0 <= sel_p0 + 3'd1;
                end else begin
                    cnt_p0 <= cnt_p0 + CW'(1);
                end
            end
            // Commit and accept are mutually exclusive: accept needs an empty buffer.
            if (boundary_p0 && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
            if (accept) pending_full <= 1'b1;

            an_p1    <= (vld_p0 && show_p0) ? ~(8'h01 << sel_p0) : 8'hFF;
            digit_p1 <= vld_p0 ? lz_nibble(active, sel_p0, blank_lz) : 4'h0;
            fs_p1    <= vld_p0 && (cnt_p0 == '0) && (sel_p0 == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pending <= load.digits_in;
    end

    assign an          = an_p1;
    assign digit       = digit_p1;
    assign frame_start = fs_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DWELL_CYCLES=10, BLANK_CYCLES=2; the reference model
// tracks position within the 80-cycle frame and the pending/active display words.
module tb_seg_scan_ctrl;

    localparam int DW    = 10;
    localparam int BL    = 2;
    localparam int FRAME = 8 * DW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       blank_lz;
    logic [3:0] digit;
    logic [7:0] an;
    logic       frame_start;

    seg_scan_if bus ();

    seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .BLANK_CODE(4'hF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (bus),
        .blank_lz    (blank_lz),
        .digit       (digit),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          fs_count = 0;
    logic [3:0]  seen [8];

    bit          m_run = 1'b0;
    bit          m_pf  = 1'b0;
    int          m_pos = 0;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_act  = 32'h0;
    logic [7:0]  exp_an;
    logic [3:0]  exp_dig;
    logic        exp_fs;
    logic        exp_rdy;
    logic [31:0] cur_word;

    function automatic logic [3:0] ref_digit(input logic [31:0] word, input int i, input logic lz);
        logic [31:0] sh;
        sh = word >> (4 * i);
        if (lz && i != 0 && sh == 32'h0) return 4'hF;
        return sh[3:0];
    endfunction

    // One clock: capture inputs, advance the frame model, note what each anode displayed.
    task automatic tick();
        logic        v_rst, v_val, v_lz;
        logic [31:0] v_dat;
        bit          acc;
        int          slot, c;
        v_rst = rst_n; v_val = bus.load_valid; v_dat = bus.digits_in; v_lz = blank_lz;
        @(posedge clk);
        #1;
        if (!v_rst) begin
            exp_an = 8'hFF; exp_dig = 4'h0; exp_fs = 1'b0;
            m_run = 1'b0; m_pos = 0; m_pf = 1'b0; m_act = 32'h0;
        end else if (!m_run) begin
            exp_an = 8'hFF; exp_dig = 4'h0; exp_fs = 1'b0;
            m_run = 1'b1;
        end else begin
            slot    = m_pos / DW;
            c       = m_pos % DW;
            exp_an  = (c < DW - BL) ? (8'hFF ^ (8'h01 << slot)) : 8'hFF;
            exp_dig = ref_digit(m_act, slot, v_lz);
            exp_fs  = (m_pos == 0);
            acc     = v_val && !m_pf;
            if (m_pos == FRAME - 1 && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end
            if (acc) begin
                m_pend = v_dat;
                m_pf   = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_rdy = m_run && !m_pf;
        for (int s = 0; s < 8; s++) if (an == (8'hFF ^ (8'h01 << s))) seen[s] = digit;
        if (frame_start === 1'b1) fs_count++;
    endtask

    task automatic advance_to(input int p);
        int n;
        n = (p - m_pos + FRAME) % FRAME;
        repeat (n) tick();
    endtask

    task automatic show_frame();
        for (int s = 0; s < 8; s++) seen[s] = 4'hx;
        repeat (FRAME) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; blank_lz = 1'b0; bus.load_valid = 1'b0; bus.digits_in = 32'h0;
        tick(); tick();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h want ff", an); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h want 0", digit); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.load_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL release_an: got %h want ff", an); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", bus.load_ready); end
        tick();
        checks++; if (an !== 8'hFE) begin errors++; $display("FAIL first_fe: got %h want fe", an); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b want 1", frame_start); end
    endtask

    task automatic test_scan();
        fs_count = 0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if ({an, digit, frame_start, bus.load_ready} !== {exp_an, exp_dig, exp_fs, exp_rdy}) begin
                errors++;
                $display("FAIL scan: got an=%h dig=%h fs=%b rdy=%b want an=%h dig=%h fs=%b rdy=%b",
                         an, digit, frame_start, bus.load_ready, exp_an, exp_dig, exp_fs, exp_rdy);
            end
        end
        checks++; if (fs_count != 2) begin errors++; $display("FAIL scan_fs_count: got %0d want 2", fs_count); end
    endtask

    task automatic test_load();
        advance_to(30);
        bus.digits_in = 32'h87654321; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop: got %b want 0", bus.load_ready); end
        for (int s = 0; s < 8; s++) seen[s] = 4'hx;
        advance_to(0);
        for (int s = 3; s < 8; s++) begin
            checks++; if (seen[s] !== 4'h0) begin errors++; $display("FAIL load_old_frame[%0d]: got %h want 0", s, seen[s]); end
        end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b want 1", bus.load_ready); end
        show_frame();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== 4'(s + 1)) begin errors++; $display("FAIL load_new_frame[%0d]: got %h want %h", s, seen[s], 4'(s + 1)); end
        end
        cur_word = 32'h87654321;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        lz;
        a = $urandom | 32'h1; b = $urandom; lz = 1'($urandom % 2);
        blank_lz = lz;
        advance_to(20);
        bus.digits_in = a; bus.load_valid = 1'b1;
        tick();
        bus.digits_in = b;
        advance_to(0);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_commit: got %b want 1", bus.load_ready); end
        for (int s = 0; s < 8; s++) seen[s] = 4'hx;
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_accept: got %b want 0", bus.load_ready); end
        repeat (FRAME - 1) tick();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== ref_digit(a, s, lz)) begin errors++; $display("FAIL b2b_frame_a[%0d]: got %h want %h", s, seen[s], ref_digit(a, s, lz)); end
        end
        show_frame();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== ref_digit(b, s, lz)) begin errors++; $display("FAIL b2b_frame_b[%0d]: got %h want %h", s, seen[s], ref_digit(b, s, lz)); end
        end
        cur_word = b;
        blank_lz = 1'b0;
    endtask

    task automatic test_boundary_load();
        logic [31:0] w;
        w = $urandom ^ cur_word;
        advance_to(FRAME - 1);
        bus.digits_in = w; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL bnd_accept: got %b want 0", bus.load_ready); end
        show_frame();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== cur_word[4*s +: 4]) begin errors++; $display("FAIL bnd_old_frame[%0d]: got %h want %h", s, seen[s], cur_word[4*s +: 4]); end
        end
        show_frame();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== w[4*s +: 4]) begin errors++; $display("FAIL bnd_new_frame[%0d]: got %h want %h", s, seen[s], w[4*s +: 4]); end
        end
    endtask

    task automatic test_lz();
        logic [31:0] words [3];
        logic        lzs   [3];
        logic [31:0] shown [3];
        words = '{32'h00000120, 32'h00000120, 32'h00000000};
        lzs   = '{1'b1, 1'b0, 1'b1};
        shown = '{32'hFFFFF120, 32'h00000120, 32'hFFFFFFF0};
        for (int k = 0; k < 3; k++) begin
            advance_to(10);
            bus.digits_in = words[k]; bus.load_valid = 1'b1; blank_lz = lzs[k];
            tick();
            bus.load_valid = 1'b0;
            advance_to(0);
            show_frame();
            for (int s = 0; s < 8; s++) begin
                checks++; if (seen[s] !== shown[k][4*s +: 4]) begin errors++; $display("FAIL lz_case%0d[%0d]: got %h want %h", k, s, seen[s], shown[k][4*s +: 4]); end
            end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            bus.load_valid = ($urandom % 4 == 0);
            bus.digits_in  = $urandom;
            blank_lz       = 1'($urandom % 2);
            tick();
            checks++;
            if ({an, digit, frame_start, bus.load_ready} !== {exp_an, exp_dig, exp_fs, exp_rdy}) begin
                errors++;
                $display("FAIL random: got an=%h dig=%h fs=%b rdy=%b want an=%h dig=%h fs=%b rdy=%b",
                         an, digit, frame_start, bus.load_ready, exp_an, exp_dig, exp_fs, exp_rdy);
            end
        end
        bus.load_valid = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_mid_reset();
        advance_to(40);
        bus.digits_in = $urandom | 32'h1; bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        advance_to(5 * DW + (DW - BL));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL mid_reset_an: got %h want ff", an); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL mid_reset_digit: got %h want 0", digit); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", bus.load_ready); end
        tick();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL mid_release_an: got %h want ff", an); end
        for (int s = 0; s < 8; s++) seen[s] = 4'hx;
        tick();
        checks++; if (an !== 8'hFE) begin errors++; $display("FAIL mid_restart_an: got %h want fe", an); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_restart_fs: got %b want 1", frame_start); end
        repeat (FRAME - 1) tick();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== 4'h0) begin errors++; $display("FAIL mid_frame1[%0d]: got %h want 0", s, seen[s]); end
        end
        show_frame();
        for (int s = 0; s < 8; s++) begin
            checks++; if (seen[s] !== 4'h0) begin errors++; $display("FAIL mid_frame2[%0d]: got %h want 0", s, seen[s]); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_lz();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
